fb_mem_port: RTL and testbench
==============================

// Module: fb_mem_port
// PURPOSE
//  Framebuffer memory port directly downstream of fb_controller. Accepts single-pixel
//  read/write requests (do_read/do_write, pix_x/pix_y, write_rgb) and maps (x,y) to a
//  linear address. Runs a wait-stated single-port SRAM access, then returns read_rgb
//  with the busy/done handshake that fb_controller consumes.
// PARAMETERS
//  WIDTH        640  frame width in pixels
//  HEIGHT       480  frame height in pixels
//  ADDR_W       19   memory address width; WIDTH*HEIGHT <= 2**ADDR_W
//  WAIT_CYCLES  2    extra SRAM cycles; mem_rdata is valid WAIT_CYCLES cycles after mem_ce rises
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  do_read    in   1       read request, sampled only while busy=0
//  do_write   in   1       write request, sampled only while busy=0
//  pix_x      in   16      pixel column
//  pix_y      in   16      pixel row
//  write_rgb  in   32      pixel data for writes
//  read_rgb   out  32      last completed read data
//  busy       out  1       request in progress
//  done       out  1       one-cycle completion pulse
//  oob        out  1       completion was out of range (valid with done)
//  mem_addr   out  ADDR_W  SRAM address
//  mem_wdata  out  32      SRAM write data
//  mem_rdata  in   32      SRAM read data
//  mem_ce     out  1       SRAM chip enable
//  mem_we     out  1       SRAM write enable (qualified by mem_ce)
// BEHAVIOUR
//  - Reset: state IDLE; read_rgb, mem_addr, mem_wdata = 0; busy, done, oob, mem_ce, mem_we = 0.
//  - States IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
//  - IDLE/DONE: busy=0. A request (do_read|do_write) sampled in either state -> SETUP next cycle.
//    DONE accepts a request, so back-to-back requests are possible.
//  - Request capture: x, y, rgb and op registered. op = write if do_write=1 (write wins when both are high).
//  - SETUP: busy=1. Register addr = y*WIDTH + x, truncated to ADDR_W.
//    Register oob_r = (x>=WIDTH)|(y>=HEIGHT). If oob_r=1 -> DONE, else -> ACCESS.
//  - ACCESS: busy=1; mem_ce=1, mem_we=op, mem_addr/mem_wdata stable.
//    Lasts exactly WAIT_CYCLES+1 cycles, counted by a down-counter.
//    On the last ACCESS edge, a read captures mem_rdata into read_rgb. Then -> DONE.
//  - DONE: done=1 and oob=oob_r for one cycle; mem_ce=mem_we=0.
//  - Out-of-range request: no mem_ce. A read loads read_rgb=0.
//  - read_rgb holds its value until the next completed read. Writes never change it.
//  - Requests while busy=1 are ignored, with no queueing.
//  - Latency, request sampled at cycle 0: in-range done at cycle 3+WAIT_CYCLES; oob done at cycle 2.
//  - Reset mid-operation: IDLE on the next edge; mem_ce/mem_we drop; no done pulse.
// TESTING  (WIDTH=32 HEIGHT=32 ADDR_W=10 WAIT_CYCLES=2)
//  1. do_write at cycle 0, x=5 y=3 rgb=AABBCCDD:
//     -> busy=1 cycles 1-4; mem_addr=101; mem_ce=mem_we=1 cycles 2-4; done=1, oob=0 at cycle 5.
//  2. do_read x=5 y=3, SRAM model returns AABBCCDD:
//     -> mem_we=0; done at cycle 5; read_rgb=AABBCCDD from cycle 5 on.
//  3. do_read x=32 y=0 -> no mem_ce; done=1, oob=1 at cycle 2; read_rgb=0.
//  4. do_read and do_write both high, x=0 y=0 rgb=12345678:
//     -> write performed, mem_wdata=12345678, mem_addr=0.
//  5. Second request at cycle 2 during busy -> ignored, one done only.
//     Request held in the DONE cycle -> accepted, SETUP next cycle.
//  6. rst=1 at cycle 3 during ACCESS -> cycle 4: all outputs 0, state IDLE, no done pulse.

Source files
------------

// File: rtl/fb_mem_port.sv
// Framebuffer pixel port: maps (x,y) to a linear SRAM address and runs one
// wait-stated single-port access per request with a busy/done handshake.
module fb_mem_port #(
   parameter int unsigned WIDTH       = 640,
   parameter int unsigned HEIGHT      = 480,
   parameter int unsigned ADDR_W      = 19,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              do_read,
   input  logic              do_write,
   input  logic [15:0]       pix_x,
   input  logic [15:0]       pix_y,
   input  logic [31:0]       write_rgb,
   output logic [31:0]       read_rgb,
   output logic              busy,
   output logic              done,
   output logic              oob,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              mem_ce,
   output logic              mem_we
);

   localparam int unsigned CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   state_t           state;
   logic [15:0]      x_r;
   logic [15:0]      y_r;
   logic [31:0]      rgb_r;
   logic             op_r;      // 1 = write
   logic             oob_r;
   logic [CNT_W-1:0] cnt;

   logic req;
   logic range_err;

   assign req       = do_read | do_write;
   assign range_err = (32'(x_r) >= WIDTH) || (32'(y_r) >= HEIGHT);

   // NOTE: all state and outputs use non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         x_r       <= '0;
         y_r       <= '0;
         rgb_r     <= '0;
         op_r      <= 1'b0;
         oob_r     <= 1'b0;
         cnt       <= '0;
         read_rgb  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         oob       <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_ce    <= 1'b0;
         mem_we    <= 1'b0;
      end else begin
         done <= 1'b0;
         oob  <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (req) begin
                  x_r   <= pix_x;
                  y_r   <= pix_y;
                  rgb_r <= write_rgb;
                  op_r  <= do_write;
                  busy  <= 1'b1;
                  state <= SETUP;
               end else begin
                  state <= IDLE;
               end
            end

            SETUP: begin
               mem_addr  <= ADDR_W'(32'(y_r) * WIDTH + 32'(x_r));
               mem_wdata <= rgb_r;
               oob_r     <= range_err;
               cnt       <= CNT_W'(WAIT_CYCLES);
               if (range_err) begin
                  // Out-of-range requests complete without touching the SRAM.
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  oob   <= 1'b1;
                  state <= DONE;
                  if (!op_r) read_rgb <= '0;
               end else begin
                  mem_ce <= 1'b1;
                  mem_we <= op_r;
                  state  <= ACCESS;
               end
            end

            ACCESS: begin
               if (cnt == '0) begin
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  oob    <= oob_r;
                  mem_ce <= 1'b0;
                  mem_we <= 1'b0;
                  state  <= DONE;
                  if (!op_r) read_rgb <= mem_rdata;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_mem_port.sv
// Self-checking bench for fb_mem_port: directed scenarios plus randomized
// requests checked cycle-by-cycle against a transaction-level model.
module tb_fb_mem_port;

   localparam int WIDTH  = 32;
   localparam int HEIGHT = 32;
   localparam int ADDR_W = 10;
   localparam int WAIT   = 2;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [15:0] x;
      logic [15:0] y;
      logic [31:0] rgb;
   } req_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              do_read;
   logic              do_write;
   logic [15:0]       pix_x;
   logic [15:0]       pix_y;
   logic [31:0]       write_rgb;
   logic [31:0]       read_rgb;
   logic              busy;
   logic              done;
   logic              oob;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ce;
   logic              mem_we;

   int n_vec = 0;
   int n_err = 0;

   fb_mem_port #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT)
   ) dut (
      .clk(clk), .rst(rst), .do_read(do_read), .do_write(do_write),
      .pix_x(pix_x), .pix_y(pix_y), .write_rgb(write_rgb), .read_rgb(read_rgb),
      .busy(busy), .done(done), .oob(oob), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ce(mem_ce), .mem_we(mem_we)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int a);
      return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   // SRAM model: read data is only valid WAIT cycles after mem_ce rises.
   logic [31:0] sram    [DEPTH];
   bit          written [DEPTH] = '{default: 1'b0};
   int          ce_cnt = 0;

   always @(posedge clk) begin
      ce_cnt <= mem_ce ? ce_cnt + 1 : 0;
      if (mem_ce && mem_we) begin
         sram[mem_addr]    <= mem_wdata;
         written[mem_addr] <= 1'b1;
      end
   end

   always_comb begin
      mem_rdata = 32'hDEAD_BEEF;
      if (mem_ce && ce_cnt >= WAIT)
         mem_rdata = written[mem_addr] ? sram[mem_addr] : pat(int'(mem_addr));
   end

   // Transaction-level reference: pixel store plus last completed read.
   logic [31:0] ref_mem [int];
   logic [31:0] exp_read = '0;

   function automatic logic [31:0] ref_rd(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : pat(a);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic req_t mk(input bit rd, input bit wr, input int x, input int y,
                               input logic [31:0] rgb);
      req_t r;
      r.rd  = rd;
      r.wr  = wr;
      r.x   = 16'(x);
      r.y   = 16'(y);
      r.rgb = rgb;
      return r;
   endfunction

   function automatic req_t rnd();
      req_t r;
      r.wr  = 1'($urandom_range(0, 1));
      r.rd  = r.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      r.x   = 16'($urandom_range(0, 35));
      r.y   = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(32, 40))
                                          : 16'($urandom_range(0, 3));
      r.rgb = $urandom;
      return r;
   endfunction

   task automatic drive(input req_t r);
      do_read   = r.rd;
      do_write  = r.wr;
      pix_x     = r.x;
      pix_y     = r.y;
      write_rgb = r.rgb;
   endtask

   task automatic clear_req();
      do_read  = 1'b0;
      do_write = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, " read_rgb"},  read_rgb,          32'd0);
      check({tag, " busy"},      32'(busy),         32'd0);
      check({tag, " done"},      32'(done),         32'd0);
      check({tag, " oob"},       32'(oob),          32'd0);
      check({tag, " mem_addr"},  32'(mem_addr),     32'd0);
      check({tag, " mem_wdata"}, mem_wdata,         32'd0);
      check({tag, " mem_ce"},    32'(mem_ce),       32'd0);
      check({tag, " mem_we"},    32'(mem_we),       32'd0);
   endtask

   task automatic step_idle(input string tag);
      @(posedge clk); #1;
      check({tag, " idle busy"},     32'(busy),   32'd0);
      check({tag, " idle done"},     32'(done),   32'd0);
      check({tag, " idle mem_ce"},   32'(mem_ce), 32'd0);
      check({tag, " idle read_rgb"}, read_rgb,    exp_read);
   endtask

   // Request r is already on the inputs, to be sampled at the next edge (cycle 0).
   // Returns in the completion cycle; if has_next, nxt is on the inputs then.
   task automatic txn(input string tag, input req_t r, input bit has_next, input req_t nxt);
      int          xi;
      int          yi;
      int          a;
      bit          oob_e;
      int          lat;
      bit          ce_e;
      logic [31:0] prev_read;
      xi        = int'(r.x);
      yi        = int'(r.y);
      oob_e     = (xi >= WIDTH) || (yi >= HEIGHT);
      lat       = oob_e ? 2 : 3 + WAIT;
      a         = (yi * WIDTH + xi) % DEPTH;
      prev_read = exp_read;
      if (r.wr) begin
         if (!oob_e) ref_mem[a] = r.rgb;
      end else begin
         exp_read = oob_e ? 32'd0 : ref_rd(a);
      end
      for (int c = 1; c <= lat; c++) begin
         @(posedge clk); #1;
         if (c < lat) begin
            // Requests while busy must be ignored.
            do_read   = 1'($urandom_range(0, 1));
            do_write  = 1'($urandom_range(0, 1));
            pix_x     = 16'($urandom);
            pix_y     = 16'($urandom);
            write_rgb = $urandom;
         end else if (has_next) begin
            drive(nxt);
         end else begin
            clear_req();
         end
         ce_e = !oob_e && c >= 2 && c < lat;
         check($sformatf("%s c%0d busy", tag, c),   32'(busy),   32'(c < lat));
         check($sformatf("%s c%0d done", tag, c),   32'(done),   32'(c == lat));
         check($sformatf("%s c%0d mem_ce", tag, c), 32'(mem_ce), 32'(ce_e));
         if (ce_e) begin
            check($sformatf("%s c%0d mem_we", tag, c),   32'(mem_we),   32'(r.wr));
            check($sformatf("%s c%0d mem_addr", tag, c), 32'(mem_addr), 32'(a));
            if (r.wr) check($sformatf("%s c%0d mem_wdata", tag, c), mem_wdata, r.rgb);
         end
         if (c < lat) begin
            check($sformatf("%s c%0d read_rgb hold", tag, c), read_rgb, prev_read);
         end else begin
            check($sformatf("%s oob", tag), 32'(oob), 32'(oob_e));
            check($sformatf("%s read_rgb", tag), read_rgb, exp_read);
            check($sformatf("%s done mem_we", tag), 32'(mem_we), 32'd0);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      req_t r;
      req_t r2;
      req_t r3;
      req_t none;
      req_t cur;
      req_t nxt;
      bit   has;

      none = mk(0, 0, 0, 0, 32'd0);
      rst = 1'b1;
      clear_req();
      pix_x = '0;
      pix_y = '0;
      write_rgb = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset");
      rst = 1'b0;
      step_idle("post_reset");

      // Write (5,3) -> address 101.
      r = mk(0, 1, 5, 3, 32'hAABB_CCDD);
      drive(r);
      txn("wr_5_3", r, 0, none);
      step_idle("wr_5_3");

      r = mk(1, 0, 5, 3, 32'd0);
      drive(r);
      txn("rd_5_3", r, 0, none);
      step_idle("rd_5_3");

      // x equal to WIDTH is out of range; read loads zero.
      r = mk(1, 0, 32, 0, 32'd0);
      drive(r);
      txn("rd_oob_x", r, 0, none);
      step_idle("rd_oob_x");

      r = mk(0, 1, 31, 32, 32'h0BAD_0BAD);
      drive(r);
      txn("wr_oob_y", r, 0, none);
      step_idle("wr_oob_y");

      // Both requests high: the write wins.
      r = mk(1, 1, 0, 0, 32'h1234_5678);
      drive(r);
      txn("rdwr_0_0", r, 0, none);
      step_idle("rdwr_0_0");
      r = mk(1, 0, 0, 0, 32'd0);
      drive(r);
      txn("rd_0_0", r, 0, none);
      step_idle("rd_0_0");

      // Back-to-back: each new request is held in the DONE cycle.
      r  = mk(0, 1, 31, 31, 32'hDEAD_C0DE);
      r2 = mk(1, 0, 31, 31, 32'd0);
      r3 = mk(1, 0, 5, 3, 32'd0);
      drive(r);
      txn("b2b_wr", r, 1, r2);
      txn("b2b_rd", r2, 1, r3);
      txn("b2b_rd2", r3, 0, none);
      step_idle("b2b");

      // Reset during ACCESS: everything clears, no done pulse follows.
      r = mk(1, 0, 9, 2, 32'd0);
      drive(r);
      @(posedge clk); #1;
      clear_req();
      @(posedge clk); #1;
      check("rst_mid c2 mem_ce", 32'(mem_ce), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset("rst_mid c4");
      exp_read = '0;
      rst = 1'b0;
      step_idle("rst_mid c5");
      step_idle("rst_mid c6");

      // Randomized requests, some chained back-to-back.
      cur = rnd();
      drive(cur);
      for (int i = 0; i < 60; i++) begin
         nxt = rnd();
         has = (i < 59) && ($urandom_range(0, 2) == 0);
         txn($sformatf("rand%0d", i), cur, has, nxt);
         if (!has) begin
            step_idle($sformatf("rand%0d", i));
            if (i < 59) drive(nxt);
         end
         cur = nxt;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
